// File: rtl/layer_sequencer.sv
// Time-multiplexed fully-connected layer: one shared MAC walks all neurons, streaming results over valid/ready.
// Optional macro LAYER_SEQ_RELU_EN clamps negative results to zero before they are registered.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

module layer_sequencer #(
  parameter int IN_N       = 16,
  parameter int OUT_N      = 8,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ACC_WIDTH  = `ACC_WIDTH,
  parameter int FRAC_BITS  = 8,
  parameter int ADDR_WIDTH = $clog2(IN_N*OUT_N)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [IN_N-1:0][DATA_WIDTH-1:0]  in_vec,
  input  logic [OUT_N-1:0][DATA_WIDTH-1:0] biases,
  output logic                             w_rd_en,
  output logic [ADDR_WIDTH-1:0]            w_addr,
  input  logic [DATA_WIDTH-1:0]            w_rdata,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(OUT_N)-1:0]         out_idx,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             busy,
  output logic                             done
);

  localparam int KW = (IN_N > 1) ? $clog2(IN_N) : 1;
  localparam int JW = $clog2(OUT_N);
  localparam logic [KW-1:0] K_LAST = KW'(IN_N - 1);
  localparam logic [JW-1:0] J_LAST = JW'(OUT_N - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_SCALE, S_OUT, S_DONE} state_t;

  state_t                        state_q;
  logic [KW-1:0]                 k_q;
  logic [KW-1:0]                 rd_idx_q;
  logic                          rd_vld_q;
  logic [JW-1:0]                 j_q;
  logic signed [ACC_WIDTH-1:0]   acc_q;
  logic                          w_rd_en_q;
  logic [ADDR_WIDTH-1:0]         w_addr_q;
  logic                          out_valid_q;
  logic [JW-1:0]                 out_idx_q;
  logic [DATA_WIDTH-1:0]         out_data_q;
  logic                          busy_q;
  logic                          done_q;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc_sum;
  logic signed [ACC_WIDTH-1:0]    scaled;
  logic [DATA_WIDTH-1:0]          result_d;
  logic [JW-1:0]                  j_inc;

  function automatic logic signed [ACC_WIDTH-1:0] bias_to_acc(input logic [DATA_WIDTH-1:0] b);
    return ACC_WIDTH'($signed(b)) <<< FRAC_BITS;
  endfunction

  // rd_idx_q tags w_rdata with the input element it must be multiplied by.
  always_comb begin
    prod    = (2*DATA_WIDTH)'($signed(in_vec[rd_idx_q])) * (2*DATA_WIDTH)'($signed(w_rdata));
    acc_sum = acc_q + ACC_WIDTH'(prod);
    scaled  = acc_q >>> FRAC_BITS;
    j_inc   = j_q + JW'(1);
    if (scaled > SAT_MAX) begin
      result_d = SAT_MAX[DATA_WIDTH-1:0];
    end else if (scaled < SAT_MIN) begin
      result_d = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      result_d = scaled[DATA_WIDTH-1:0];
    end
`ifdef LAYER_SEQ_RELU_EN
    if (result_d[DATA_WIDTH-1]) begin
      result_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      rd_idx_q    <= '0;
      rd_vld_q    <= 1'b0;
      j_q         <= '0;
      acc_q       <= '0;
      w_rd_en_q   <= 1'b0;
      w_addr_q    <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      rd_vld_q <= w_rd_en_q;
      rd_idx_q <= k_q;
      if (rd_vld_q) begin
        acc_q <= acc_sum;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            j_q       <= '0;
            k_q       <= '0;
            acc_q     <= bias_to_acc(biases[0]);
            w_rd_en_q <= 1'b1;
            w_addr_q  <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_MAC;
          end
        end
        S_MAC: begin
          if (k_q == K_LAST) begin
            w_rd_en_q <= 1'b0;
            state_q   <= S_DRAIN;
          end else begin
            k_q      <= k_q + KW'(1);
            w_addr_q <= w_addr_q + ADDR_WIDTH'(1);
          end
        end
        // Last weight lands this cycle; the accumulate above absorbs it.
        S_DRAIN: state_q <= S_SCALE;
        S_SCALE: begin
          out_data_q  <= result_d;
          out_idx_q   <= j_q;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (j_q == J_LAST) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              // Rows are contiguous, so the next neuron's address just continues counting.
              j_q       <= j_inc;
              k_q       <= '0;
              acc_q     <= bias_to_acc(biases[j_inc]);
              w_rd_en_q <= 1'b1;
              w_addr_q  <= w_addr_q + ADDR_WIDTH'(1);
              state_q   <= S_MAC;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign w_rd_en   = w_rd_en_q;
  assign w_addr    = w_addr_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Time-multiplexed controller for one fully-connected layer: a single shared MAC computes all OUT_N neurons in turn, instead of OUT_N parallel perceptrons.
- Fetches weights from an external synchronous weight memory and accumulates over IN_N inputs.
- Adds the bias, rescales and saturates, then streams one result per neuron over a valid/ready port.
- Sits between the weight store and the next layer's input buffer; kicked off by start, reports done.

Parameters:
- IN_N, 16, input vector dimensionality
- OUT_N, 8, output vector dimensionality
- DATA_WIDTH, `DATA_WIDTH, signed fixed-point data width
- ACC_WIDTH, `ACC_WIDTH, signed accumulator width (must be >= 2*DATA_WIDTH)
- FRAC_BITS, 8, fractional bits of the data format
- ADDR_WIDTH, $clog2(IN_N*OUT_N), weight memory address width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- start  in  1  begin layer evaluation; sampled only in IDLE
- in_vec  in  DATA_WIDTH x IN_N  signed input vector; held stable while busy
- biases  in  DATA_WIDTH x OUT_N  signed biases; held stable while busy
- w_rd_en  out  1  weight memory read enable
- w_addr  out  ADDR_WIDTH  weight address = j*IN_N + k
- w_rdata  in  DATA_WIDTH  signed weight; valid exactly 1 cycle after w_rd_en
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_idx  out  $clog2(OUT_N)  neuron index j of out_data
- out_data  out  DATA_WIDTH  signed saturated result
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (async assert): state=IDLE; w_rd_en, w_addr, out_valid, out_idx, out_data, busy, done all 0; accumulator and counters j, k cleared. Reset mid-operation aborts immediately with no partial output; restart requires a new start.
- IDLE: busy=0. On start=1, set j=0, k=0, acc = sign-extended bias[0] << FRAC_BITS, go to MAC, busy=1.
- MAC (IN_N cycles):
  - Each cycle: w_rd_en=1, w_addr=j*IN_N+k, k++.
  - Each cycle after the first: acc += in_vec[k-1]*w_rdata, using a full 2*DATA_WIDTH signed product, sign-extended.
  - After issuing k=IN_N-1, go to DRAIN.
- DRAIN (1 cycle): w_rd_en=0; accumulate the last product. Compute r = acc >>> FRAC_BITS (arithmetic shift), saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Register it into out_data, set out_idx=j, out_valid=1, go to OUT.
- Latency: out_valid for neuron j rises IN_N+2 clock edges after its MAC entry. From the start edge, the first out_valid is visible after edge IN_N+2.
- OUT: hold out_valid, out_data, out_idx stable until out_valid&&out_ready.
  - On handshake with j<OUT_N-1: out_valid=0, j++, k=0, acc=bias[j+1]<<FRAC_BITS, go to MAC.
  - On handshake with j==OUT_N-1: out_valid=0, go to DONE.
  - out_ready=1 in the same cycle out_valid rises counts as a handshake on that edge.
- DONE (1 cycle): done=1, busy=0 next, go to IDLE.
- start is ignored outside IDLE. start held high continuously re-launches from IDLE after each DONE.
- Accumulator wraps modulo 2^ACC_WIDTH; no internal saturation. Saturation applies only at the output stage.
- out_ready is ignored when out_valid=0.
- Weight read ports are never driven when not in MAC: w_rd_en=0 and w_addr holds its last value.

Optional Feature:
- LAYER_SEQ_RELU_EN.
- Defined: after shift and saturation, negative results are forced to 0 (ReLU) before registering into out_data.
- Undefined: signed saturated result passes through unchanged.

Test Plan (IN_N=4, OUT_N=2, DATA_WIDTH=16, ACC_WIDTH=32, FRAC_BITS=8; memory returns data 1 cycle after w_rd_en; out_ready=1 unless stated):
- Basic: in_vec=[256,512,-256,0], row0 w=[256,256,256,256], bias0=128; row1 w=[-256,-256,-256,-256], bias1=-128 -> out (idx0,640), then (idx1,-640); done pulses once; w_addr sequence 0..3, 4..7.
- Latency: start at edge 0 -> out_valid first high after edge 6. busy high from edge 1 until done; done lasts exactly 1 cycle.
- Saturation: in_vec=[32767,32767,0,0], row0 w=[32767,32767,0,0], row1 w=[-32768,-32768,0,0], biases 0 -> out_data 32767 then -32768.
- Backpressure: out_ready=0 for 5 cycles at neuron 0 -> out_valid, out_data=640, out_idx=0 held stable; no w_rd_en during the stall; neuron 1 begins the cycle after the handshake.
- Reset mid-MAC: assert rst_n=0 during neuron 1 MAC -> all outputs 0 immediately; a new start repeats the basic-test results exactly. start pulses while busy have no effect.
- With LAYER_SEQ_RELU_EN: basic stimulus -> 640 then 0.
